operand_memory: RTL and testbench

Capture-and-hold register bank for the convolution datapath. After reset release it samples one 4×4 image tile (16 pixels) and one 3×3 filter kernel (9 coefficients), all 8-bit. It then freezes them and raises `done_memory` so downstream compute stages can read stable operands. It sits between the operand source and the convolution/MAC stage.

---
 rtl/operand_memory.sv | 154 +++++++++++++++
 tb/tb_operand_memory.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/operand_memory.sv
// Capture-and-hold operand bank: grabs one 4x4 image tile and one 3x3 kernel on the
// first edge after reset release, then freezes them and holds done_memory high.
module operand_memory (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_1,
  input  logic [7:0] in_2,
  input  logic [7:0] in_3,
  input  logic [7:0] in_4,
  input  logic [7:0] in_5,
  input  logic [7:0] in_6,
  input  logic [7:0] in_7,
  input  logic [7:0] in_8,
  input  logic [7:0] in_9,
  input  logic [7:0] in_10,
  input  logic [7:0] in_11,
  input  logic [7:0] in_12,
  input  logic [7:0] in_13,
  input  logic [7:0] in_14,
  input  logic [7:0] in_15,
  input  logic [7:0] in_16,
  input  logic [7:0] f_1,
  input  logic [7:0] f_2,
  input  logic [7:0] f_3,
  input  logic [7:0] f_4,
  input  logic [7:0] f_5,
  input  logic [7:0] f_6,
  input  logic [7:0] f_7,
  input  logic [7:0] f_8,
  input  logic [7:0] f_9,
  output logic [7:0] out_in_1,
  output logic [7:0] out_in_2,
  output logic [7:0] out_in_3,
  output logic [7:0] out_in_4,
  output logic [7:0] out_in_5,
  output logic [7:0] out_in_6,
  output logic [7:0] out_in_7,
  output logic [7:0] out_in_8,
  output logic [7:0] out_in_9,
  output logic [7:0] out_in_10,
  output logic [7:0] out_in_11,
  output logic [7:0] out_in_12,
  output logic [7:0] out_in_13,
  output logic [7:0] out_in_14,
  output logic [7:0] out_in_15,
  output logic [7:0] out_in_16,
  output logic [7:0] out_f_1,
  output logic [7:0] out_f_2,
  output logic [7:0] out_f_3,
  output logic [7:0] out_f_4,
  output logic [7:0] out_f_5,
  output logic [7:0] out_f_6,
  output logic [7:0] out_f_7,
  output logic [7:0] out_f_8,
  output logic [7:0] out_f_9,
  output logic       done_memory,
  output logic       fsm_state
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       capture;
  logic [7:0] img_d [16];
  logic [7:0] img_q [16];
  logic [7:0] flt_d [9];
  logic [7:0] flt_q [9];

  assign img_d[0]  = in_1;
  assign img_d[1]  = in_2;
  assign img_d[2]  = in_3;
  assign img_d[3]  = in_4;
  assign img_d[4]  = in_5;
  assign img_d[5]  = in_6;
  assign img_d[6]  = in_7;
  assign img_d[7]  = in_8;
  assign img_d[8]  = in_9;
  assign img_d[9]  = in_10;
  assign img_d[10] = in_11;
  assign img_d[11] = in_12;
  assign img_d[12] = in_13;
  assign img_d[13] = in_14;
  assign img_d[14] = in_15;
  assign img_d[15] = in_16;
  assign flt_d[0]  = f_1;
  assign flt_d[1]  = f_2;
  assign flt_d[2]  = f_3;
  assign flt_d[3]  = f_4;
  assign flt_d[4]  = f_5;
  assign flt_d[5]  = f_6;
  assign flt_d[6]  = f_7;
  assign flt_d[7]  = f_8;
  assign flt_d[8]  = f_9;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // IDLE lasts exactly one edge after release: that edge captures, then HOLD is terminal.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD:    state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) img_q[i] <= 8'h00;
      for (int i = 0; i < 9; i++)  flt_q[i] <= 8'h00;
    end else if (capture) begin
      for (int i = 0; i < 16; i++) img_q[i] <= img_d[i];
      for (int i = 0; i < 9; i++)  flt_q[i] <= flt_d[i];
    end
  end

  // done_memory is a level taken straight from the state flop; it only drops on reset.
  assign done_memory = (state_q == HOLD);
  assign fsm_state   = state_q;

  assign out_in_1  = img_q[0];
  assign out_in_2  = img_q[1];
  assign out_in_3  = img_q[2];
  assign out_in_4  = img_q[3];
  assign out_in_5  = img_q[4];
  assign out_in_6  = img_q[5];
  assign out_in_7  = img_q[6];
  assign out_in_8  = img_q[7];
  assign out_in_9  = img_q[8];
  assign out_in_10 = img_q[9];
  assign out_in_11 = img_q[10];
  assign out_in_12 = img_q[11];
  assign out_in_13 = img_q[12];
  assign out_in_14 = img_q[13];
  assign out_in_15 = img_q[14];
  assign out_in_16 = img_q[15];
  assign out_f_1   = flt_q[0];
  assign out_f_2   = flt_q[1];
  assign out_f_3   = flt_q[2];
  assign out_f_4   = flt_q[3];
  assign out_f_5   = flt_q[4];
  assign out_f_6   = flt_q[5];
  assign out_f_7   = flt_q[6];
  assign out_f_8   = flt_q[7];
  assign out_f_9   = flt_q[8];

endmodule

// File: tb/tb_operand_memory.sv
// Bench for operand_memory: table of capture/hold vectors, each preceded by a reset pulse
// landing between edges, with expected snapshots queued and compared after each edge.
module tb_operand_memory;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din_img [16];
  logic [7:0] din_flt [9];
  logic [7:0] dout_img [16];
  logic [7:0] dout_flt [9];
  logic       done_memory;
  logic       fsm_state;

  typedef logic [200:0] obs_t;

  typedef struct {
    logic [127:0] img;
    logic [71:0]  flt;
    int           hold_n;
    logic [7:0]   hold_val;
    bit           rand_hold;
  } vec_t;

  vec_t       vecs [6];
  obs_t       exp_q [$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_img [16];
  logic [7:0] m_flt [9];
  logic       m_done;

  always #5 clk = ~clk;

  operand_memory dut (
    .clk(clk), .rst(rst),
    .in_1(din_img[0]),   .in_2(din_img[1]),   .in_3(din_img[2]),   .in_4(din_img[3]),
    .in_5(din_img[4]),   .in_6(din_img[5]),   .in_7(din_img[6]),   .in_8(din_img[7]),
    .in_9(din_img[8]),   .in_10(din_img[9]),  .in_11(din_img[10]), .in_12(din_img[11]),
    .in_13(din_img[12]), .in_14(din_img[13]), .in_15(din_img[14]), .in_16(din_img[15]),
    .f_1(din_flt[0]), .f_2(din_flt[1]), .f_3(din_flt[2]), .f_4(din_flt[3]), .f_5(din_flt[4]),
    .f_6(din_flt[5]), .f_7(din_flt[6]), .f_8(din_flt[7]), .f_9(din_flt[8]),
    .out_in_1(dout_img[0]),   .out_in_2(dout_img[1]),   .out_in_3(dout_img[2]),
    .out_in_4(dout_img[3]),   .out_in_5(dout_img[4]),   .out_in_6(dout_img[5]),
    .out_in_7(dout_img[6]),   .out_in_8(dout_img[7]),   .out_in_9(dout_img[8]),
    .out_in_10(dout_img[9]),  .out_in_11(dout_img[10]), .out_in_12(dout_img[11]),
    .out_in_13(dout_img[12]), .out_in_14(dout_img[13]), .out_in_15(dout_img[14]),
    .out_in_16(dout_img[15]),
    .out_f_1(dout_flt[0]), .out_f_2(dout_flt[1]), .out_f_3(dout_flt[2]),
    .out_f_4(dout_flt[3]), .out_f_5(dout_flt[4]), .out_f_6(dout_flt[5]),
    .out_f_7(dout_flt[6]), .out_f_8(dout_flt[7]), .out_f_9(dout_flt[8]),
    .done_memory(done_memory), .fsm_state(fsm_state)
  );

  // Layout: bit 200 done, then out_in_1..16, then out_f_1..9 (MSB first).
  function automatic obs_t sample();
    obs_t r;
    r = '0;
    r[200] = done_memory;
    for (int k = 0; k < 16; k++) r[199-8*k -: 8] = dout_img[k];
    for (int k = 0; k < 9; k++)  r[71-8*k -: 8]  = dout_flt[k];
    return r;
  endfunction

  function automatic obs_t model_obs();
    obs_t r;
    r = '0;
    r[200] = m_done;
    for (int k = 0; k < 16; k++) r[199-8*k -: 8] = m_img[k];
    for (int k = 0; k < 9; k++)  r[71-8*k -: 8]  = m_flt[k];
    return r;
  endfunction

  task automatic model_clear();
    m_done = 1'b0;
    for (int k = 0; k < 16; k++) m_img[k] = 8'h00;
    for (int k = 0; k < 9; k++)  m_flt[k] = 8'h00;
  endtask

  task automatic model_capture();
    m_done = 1'b1;
    for (int k = 0; k < 16; k++) m_img[k] = din_img[k];
    for (int k = 0; k < 9; k++)  m_flt[k] = din_flt[k];
  endtask

  task automatic check(input string name);
    obs_t a, e;
    a = sample();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, a);
      return;
    end
    e = exp_q.pop_front();
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < 16; k++) din_img[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++)  din_flt[k] = 8'($urandom_range(0, 255));
  endtask

  // Reset pulse lands mid-cycle; outputs must clear before any edge arrives.
  task automatic reset_pulse(input int v);
    @(negedge clk);
    #1 rst = 1'b0;
    model_clear();
    exp_q.push_back(model_obs());
    #1 check($sformatf("async_reset_v%0d", v));
  endtask

  task automatic capture_vec(input int v);
    for (int k = 0; k < 16; k++) din_img[k] = vecs[v].img[127-8*k -: 8];
    for (int k = 0; k < 9; k++)  din_flt[k] = vecs[v].flt[71-8*k -: 8];
    #1 rst = 1'b1;
    exp_q.push_back(model_obs());
    #1 check($sformatf("pre_edge_v%0d", v));
    @(posedge clk);
    model_capture();
    exp_q.push_back(model_obs());
    #1 check($sformatf("capture_v%0d", v));
  endtask

  task automatic hold_vec(input int v);
    for (int c = 0; c < vecs[v].hold_n; c++) begin
      @(negedge clk);
      if (vecs[v].rand_hold) randomize_inputs();
      else begin
        for (int k = 0; k < 16; k++) din_img[k] = vecs[v].hold_val;
        for (int k = 0; k < 9; k++)  din_flt[k] = vecs[v].hold_val;
      end
      @(posedge clk);
      exp_q.push_back(model_obs());
      #1 check($sformatf("hold_v%0d_c%0d", v, c));
    end
  endtask

  initial begin
    // Spec tile/kernel, all-A5, walking one, all-FF, all-zero, random.
    vecs[0] = '{img: 128'hD5_37_AC_52_65_EA_97_2D_C9_B8_79_1C_55_FF_01_AA,
                flt: 72'h3C_DB_A5_4E_E3_16_71_B9_56,
                hold_n: 5, hold_val: 8'h00, rand_hold: 1'b0};
    vecs[1] = '{img: {16{8'hA5}}, flt: {9{8'hA5}}, hold_n: 2, hold_val: 8'hFF, rand_hold: 1'b0};
    vecs[2] = '{img: '0, flt: '0, hold_n: 3, hold_val: 8'h00, rand_hold: 1'b1};
    for (int k = 1; k <= 16; k++) vecs[2].img[127-8*(k-1) -: 8] = 8'(8'h01 << (k % 8));
    for (int k = 1; k <= 9; k++)  vecs[2].flt[71-8*(k-1) -: 8]  = 8'(8'h01 << (k % 8));
    vecs[3] = '{img: {16{8'hFF}}, flt: {9{8'hFF}}, hold_n: 2, hold_val: 8'h5A, rand_hold: 1'b0};
    vecs[4] = '{img: '0, flt: '0, hold_n: 2, hold_val: 8'hC3, rand_hold: 1'b0};
    vecs[5] = '{img: '0, flt: '0, hold_n: 3, hold_val: 8'h00, rand_hold: 1'b1};
    for (int k = 0; k < 16; k++) vecs[5].img[127-8*k -: 8] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++)  vecs[5].flt[71-8*k -: 8]  = 8'($urandom_range(0, 255));

    // Held in reset with arbitrary inputs: everything stays cleared across edges.
    rst = 1'b0;
    randomize_inputs();
    model_clear();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      exp_q.push_back(model_obs());
      #1 check($sformatf("reset_hold_c%0d", c));
      @(negedge clk);
      randomize_inputs();
    end

    for (int v = 0; v < 6; v++) begin
      reset_pulse(v);
      capture_vec(v);
      hold_vec(v);
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
